soc_bus_xbar: RTL
=================

// Module: soc_bus_xbar
// PURPOSE
//  Parametrised 1-master / N-slave memory-mapped interconnect between the j4fsoc core and its peripherals.
//  It generalises the fixed single-ROM hookup to N address-decoded slaves (boot ROM, UART, PLIC, ...).
//  Adds valid/ready handshakes, decode-error responses and an optional bus timeout.
//  Supports one transaction in flight; slave address is region-relative.
// PARAMETERS
//  XLEN        32                      data/address width (bits)
//  NSLAVES     3                       number of slave ports (1..8)
//  SLV_BASE    {PLIC,UART,BOOTROM}     packed [NSLAVES*XLEN], slave i base at [i*XLEN+:XLEN]
//  SLV_RANGE   {32'h1000 x3}           packed [NSLAVES*XLEN], region size in bytes, nonzero
//  TIMEOUT     255                     cycles before timeout error (only with SOC_BUS_TIMEOUT_EN)
// PORTS
//  clk          in   1             system clock, all logic on posedge
//  rst_n        in   1             synchronous active-low reset
//  m_req_valid  in   1             master request valid
//  m_req_ready  out  1             master request accepted when valid&&ready
//  m_req_addr   in   XLEN          absolute byte address
//  m_req_we     in   1             1 = write, 0 = read
//  m_req_wdata  in   XLEN          write data
//  m_req_be     in   XLEN/8        byte enables
//  m_rsp_valid  out  1             one-cycle response pulse (master always accepts)
//  m_rsp_rdata  out  XLEN          read data, 0 on error or write
//  m_rsp_err    out  1             decode/slave/timeout error, qualified by m_rsp_valid
//  s_req_valid  out  NSLAVES       one-hot request valid to the selected slave
//  s_req_ready  in   NSLAVES       per-slave request ready
//  s_req_addr   out  XLEN          shared, m_req_addr - SLV_BASE[sel]
//  s_req_we     out  1             shared
//  s_req_wdata  out  XLEN          shared
//  s_req_be     out  XLEN/8        shared
//  s_rsp_valid  in   NSLAVES       per-slave response pulse
//  s_rsp_rdata  in   NSLAVES*XLEN  slave i at [i*XLEN+:XLEN]
//  s_rsp_err    in   NSLAVES       per-slave error
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; m_req_ready=0 during reset.
//    m_rsp_valid=0, m_rsp_rdata=0, m_rsp_err=0, s_req_valid=0, timeout counter=0.
//  - Reset mid-transaction aborts it silently: no response is issued.
//  - Decode: slave i hits if SLV_BASE[i] <= addr < SLV_BASE[i]+SLV_RANGE[i], computed as XLEN+1-bit unsigned.
//    If regions overlap, the lowest index wins. No hit = decode error.
//  - FSM IDLE: m_req_ready=1. On accept, latch addr/we/wdata/be and the select index.
//    Hit -> REQ. Miss -> ERR.
//  - FSM REQ: s_req_valid[sel]=1, all other bits 0; shared signals come from the latched registers.
//    When s_req_ready[sel]=1 -> RSP. A slave may assert ready and rsp_valid in the same cycle:
//    take the response then and go to IDLE.
//  - FSM RSP: wait for s_rsp_valid[sel]. On it, register rdata (0 if we=1) and err.
//    Next cycle m_rsp_valid=1; state -> IDLE.
//  - FSM ERR: next cycle m_rsp_valid=1, m_rsp_err=1, m_rsp_rdata=0; -> IDLE. No slave sees the request.
//  - Minimum latency, zero-wait slave: accept at T, s_req_valid at T+1, response at T+1, m_rsp_valid at T+2.
//  - Next accept is possible in the same cycle m_rsp_valid is high.
//  - m_req_ready is 0 in REQ/RSP/ERR.
//  - Ignored responses: s_rsp_valid from any non-selected slave, or in IDLE/ERR.
//  - Master must hold its request stable only up to the accept cycle.
// CONFIGURATION
//  SOC_BUS_TIMEOUT_EN defined: a counter clears on accept and counts cycles in REQ/RSP.
//    When it reaches TIMEOUT with no completion: deassert s_req_valid, respond err=1 rdata=0 next cycle, -> IDLE.
//    A later stray response from that slave is ignored.
//  SOC_BUS_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; TIMEOUT is unused.
// TESTING
//  1. Read 32'h8000_0010, ROM slave0 ready=1, rsp rdata=32'h1234_5678 same cycle
//     -> s_req_addr=32'h10, m_rsp_valid at T+2, rdata=32'h1234_5678, err=0.
//  2. Write 32'h1000_0004 wdata=32'hA5, be=4'b0001, UART ready after 3 cycles
//     -> s_req_valid[1] high 4 cycles, s_req_addr=4, response rdata=0, err=0.
//  3. Read 32'h2000_0000 (unmapped) -> no s_req_valid, m_rsp_valid at T+2 with err=1, rdata=0.
//  4. Edge addresses: 32'h0C00_0FFF -> PLIC slave2, addr 32'hFFF;
//     32'h0C00_1000 -> decode error.
//  5. TIMEOUT_EN, TIMEOUT=8, slave never responds -> err=1 after 8 REQ/RSP cycles.
//     Then a late s_rsp_valid is ignored and the next read completes normally.
//  6. Assert rst_n=0 while in RSP -> all outputs 0 next cycle, no m_rsp_valid.
//     Back-to-back accept on the m_rsp_valid cycle is also verified.

Source files
------------

// File: rtl/soc_bus_xbar.sv
// soc_bus_xbar: 1-master / N-slave address-decoded interconnect, one transaction in flight.
// Define SOC_BUS_TIMEOUT_EN to enable the bus timeout counter (TIMEOUT cycles in REQ/RSP).
module soc_bus_xbar #(
    parameter int XLEN    = 32,
    parameter int NSLAVES = 3,
    parameter logic [NSLAVES*XLEN-1:0] SLV_BASE  = {32'h0C00_0000, 32'h1000_0000, 32'h8000_0000},
    parameter logic [NSLAVES*XLEN-1:0] SLV_RANGE = {3{32'h0000_1000}},
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_req_valid,
    output logic                    m_req_ready,
    input  logic [XLEN-1:0]         m_req_addr,
    input  logic                    m_req_we,
    input  logic [XLEN-1:0]         m_req_wdata,
    input  logic [XLEN/8-1:0]       m_req_be,
    output logic                    m_rsp_valid,
    output logic [XLEN-1:0]         m_rsp_rdata,
    output logic                    m_rsp_err,
    output logic [NSLAVES-1:0]      s_req_valid,
    input  logic [NSLAVES-1:0]      s_req_ready,
    output logic [XLEN-1:0]         s_req_addr,
    output logic                    s_req_we,
    output logic [XLEN-1:0]         s_req_wdata,
    output logic [XLEN/8-1:0]       s_req_be,
    input  logic [NSLAVES-1:0]      s_rsp_valid,
    input  logic [NSLAVES*XLEN-1:0] s_rsp_rdata,
    input  logic [NSLAVES-1:0]      s_rsp_err
);

    localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Illegal configurations elaborate no logic here; TIMEOUT must be at least 1.
    if (NSLAVES < 1 || NSLAVES > 8 || TIMEOUT < 1) begin : g_bad_config
    end

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN/8-1:0] be_q, be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef SOC_BUS_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_hit;
`endif

    // Address decode, done XLEN+1 bits wide so a region ending at the top of memory still works.
    logic [NSLAVES-1:0] hit;
    logic [XLEN-1:0]    base_arr  [NSLAVES];
    logic [XLEN-1:0]    rdata_arr [NSLAVES];

    for (genvar i = 0; i < NSLAVES; i++) begin : g_slv
        logic [XLEN:0] lo;
        logic [XLEN:0] hi;
        assign base_arr[i]  = SLV_BASE[i*XLEN +: XLEN];
        assign rdata_arr[i] = s_rsp_rdata[i*XLEN +: XLEN];
        assign lo           = {1'b0, SLV_BASE[i*XLEN +: XLEN]};
        assign hi           = lo + {1'b0, SLV_RANGE[i*XLEN +: XLEN]};
        assign hit[i]       = ({1'b0, m_req_addr} >= lo) && ({1'b0, m_req_addr} < hi);
    end

    logic [SEL_W-1:0] hit_sel;
    logic             hit_any;

    // Scan downwards so the lowest matching index wins on overlap.
    always_comb begin
        hit_sel = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_sel = i[SEL_W-1:0];
            end
        end
    end

    assign hit_any = |hit;

    logic            sel_ready;
    logic            sel_rsp_valid;
    logic            sel_rsp_err;
    logic [XLEN-1:0] sel_rdata;
    logic            done;

    assign sel_ready     = s_req_ready[sel_q];
    assign sel_rsp_valid = s_rsp_valid[sel_q];
    assign sel_rsp_err   = s_rsp_err[sel_q];
    assign sel_rdata     = rdata_arr[sel_q];

    // A response counts in REQ only when the slave also accepts in that cycle.
    assign done = sel_rsp_valid && ((state_q == ST_RSP) || ((state_q == ST_REQ) && sel_ready));

`ifdef SOC_BUS_TIMEOUT_EN
    assign tmo_hit = (tmo_cnt_q == 32'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
`ifdef SOC_BUS_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m_req_valid) begin
                    sel_d   = hit_sel;
                    addr_d  = m_req_addr - base_arr[hit_sel];
                    we_d    = m_req_we;
                    wdata_d = m_req_wdata;
                    be_d    = m_req_be;
                    state_d = hit_any ? ST_REQ : ST_ERR;
`ifdef SOC_BUS_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_REQ, ST_RSP: begin
                if (done) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (we_q || sel_rsp_err) ? '0 : sel_rdata;
                    rsp_err_d   = sel_rsp_err;
                    state_d     = ST_IDLE;
                end
`ifdef SOC_BUS_TIMEOUT_EN
                else if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end
`endif
                else if ((state_q == ST_REQ) && sel_ready) begin
                    state_d = ST_RSP;
                end
`ifdef SOC_BUS_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
            end
            ST_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef SOC_BUS_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef SOC_BUS_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    always_comb begin
        s_req_valid = '0;
        if (state_q == ST_REQ) begin
            s_req_valid[sel_q] = 1'b1;
        end
    end

    assign m_req_ready = rst_n && (state_q == ST_IDLE);
    assign m_rsp_valid = rsp_valid_q;
    assign m_rsp_rdata = rsp_rdata_q;
    assign m_rsp_err   = rsp_err_q;
    assign s_req_addr  = addr_q;
    assign s_req_we    = we_q;
    assign s_req_wdata = wdata_q;
    assign s_req_be    = be_q;

endmodule
